mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter for one single-ported, one-cycle-read-latency memory port (code/data RAM and the same-shaped peripheral decode behind it). Requester 0 is the CPU pipeline, which has priority and no ready. Requester 1 is an external master, such as a UART loader or debug DMA, with a valid/ready handshake. The block sits between the pipeline memory port and the memory/peripheral decode, and returns read data to whichever requester owned the previous cycle.

## Interface
- AW, 32: address width.
- STARVE_LIMIT, 15: wait cycles before the starvation guard steals a slot (range 1..255).

- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- cpu_valid, cpu_write  in  1  CPU request / write
- cpu_wmask  in  4  CPU byte enables
- cpu_wdata  in  32  CPU write data
- cpu_addr  in  AW  CPU address
- cpu_rdata  out  32  read data, valid 1 cycle after the CPU request
- cpu_stall  out  1  CPU must hold its request this cycle
- ext_valid, ext_write  in  1  external request / write
- ext_wmask  in  4  external byte enables
- ext_wdata  in  32  external write data
- ext_addr  in  AW  external address
- ext_ready  out  1  external request accepted this cycle
- ext_rvalid  out  1  ext_rdata valid
- ext_rdata  out  32  external read data
- mem_valid, mem_write  out  1  memory request / write
- mem_wmask  out  4  memory byte enables
- mem_wdata  out  32  memory write data
- mem_addr  out  AW  memory address
- mem_rdata  in  32  memory read data, 1 cycle after the address

## Operation
- **Grant (combinational):** ext owns the port when (~cpu_valid | steal) & ext_valid. Otherwise the CPU owns it.
- **CPU-owned cycle:** mem_* = cpu_*.
- **Idle cycle (no requester):** mem_valid=0; mem_addr=cpu_addr, so speculative CPU reads still see data next cycle.
- **ext_ready** = ext grant. A handshake is ext_valid & ext_ready.
  - A write completes in the handshake cycle.
  - A read returns on ext_rvalid in the next cycle.
- **q_Owner:** register recording who owned the cycle (CPU/EXT/NONE).
  - cpu_rdata = mem_rdata unconditionally.
  - ext_rdata = mem_rdata.
  - ext_rvalid = (q_Owner==EXT) & q_ExtRead.
- **Starvation guard FSM (q_State), with q_Wait counting 0..STARVE_LIMIT:**
  - IDLE → WAIT when ext_valid & ~ext_ready. q_Wait=1.
  - WAIT: q_Wait increments each blocked cycle.
    - → STEAL when q_Wait==STARVE_LIMIT.
    - → IDLE on handshake or when ext_valid drops.
  - STEAL: steal=1 and cpu_stall=1 for exactly one cycle; ext is granted. → IDLE, q_Wait=0.
- ext_valid dropping while in WAIT: return to IDLE, no steal.
- A stalled CPU must present the same request again in the next cycle.
  - cpu_rdata in the cycle after STEAL carries ext data; the CPU discards it.
- ext_* inputs must stay stable while ext_valid & ~ext_ready.
- **Reset:** cpu_stall=0, ext_ready=0 (combinational, forced), ext_rvalid=0, q_Owner=NONE, q_State=IDLE, q_Wait=0. An in-flight ext read response is dropped.

## Timing
- CPU path adds zero cycles. Memory read latency stays at 1 cycle.
- ext read latency: ext_rvalid exactly 1 cycle after the handshake.
- ext throughput: one access per cycle while the CPU is idle.
- Worst-case ext wait under continuous CPU traffic: STARVE_LIMIT+1 cycles.
- cpu_stall is combinational from q_State only, so there is no path from cpu_valid.
- Simultaneous cpu_valid & ext_valid in STEAL: ext wins. In all other states: CPU wins.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: FSM, q_Wait and steal logic are present as above.
- Not defined:
  - cpu_stall tied 0; no counter or FSM.
  - ext is granted only in cycles with cpu_valid=0 and may wait indefinitely.
  - STARVE_LIMIT is ignored.

## Structure
- Package mem_arb_pkg holds:
  - owner enum (OWN_NONE, OWN_CPU, OWN_EXT)
  - guard state enum (ST_IDLE, ST_WAIT, ST_STEAL)
  - default STARVE_LIMIT constant
- One sub-module, mem_arb_starve_guard: q_State/q_Wait FSM.
  - Inputs: ext_valid, ext_ready.
  - Outputs: steal.
  - Instantiated only under MEM_ARB_STARVE_GUARD_EN.

## Test plan
- **CPU only:** cpu read of addr 0x8000_0010 holding 0x1234_5678 → mem_addr=0x8000_0010 same cycle; cpu_rdata=0x1234_5678 next cycle; ext_rvalid=0.
- **Ext in idle slot:** cpu_valid=0, ext write 0xDEAD_BEEF to 0x8004_0000 mask 4'b1111 → ext_ready=1 same cycle. An ext read of the same address then gives ext_rvalid=1, ext_rdata=0xDEAD_BEEF one cycle later.
- **Contention:** cpu_valid=1 and ext_valid=1 simultaneously, guard idle → CPU granted; ext_ready=0; cpu_stall=0.
- **Starvation (macro on, STARVE_LIMIT=3):** cpu_valid held 1, ext_valid held 1 → ext_ready=0 for 4 cycles; in the 5th cycle cpu_stall=1, ext_ready=1; the next cycle cpu_stall=0 and the CPU is granted again.
- **Macro off:** same stimulus for 300 cycles → cpu_stall never 1; ext_ready never 1.
- **Reset mid-read:** ext read handshake, then rstn=0 the next cycle → ext_rvalid=0; q_Wait=0; cpu_stall=0 throughout reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: owner/guard-state types and the default starvation limit
// shared by mem_port_arbiter and its starvation guard.
package mem_arb_pkg;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_EXT} owner_t;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STEAL} guard_state_t;
   localparam int STARVE_LIMIT_DEF = 15;
endpackage

// File: rtl/mem_arb_starve_guard.sv
// mem_arb_starve_guard: counts cycles the external master is refused and
// raises steal for one cycle once it has waited STARVE_LIMIT+1 cycles.
module mem_arb_starve_guard
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic ext_valid,
   input  logic ext_ready,
   output logic steal
);
   guard_state_t q_state, d_state;
   logic [7:0] q_wait, d_wait;

   always_ff @(posedge clk)
      if (!rstn) begin
         q_state <= ST_IDLE;
         q_wait  <= '0;
      end else begin
         q_state <= d_state;
         q_wait  <= d_wait;
      end

   always_comb begin
      d_state = q_state;
      d_wait  = q_wait;
      case (q_state)
         ST_IDLE:
            if (ext_valid & ~ext_ready) begin
               d_state = ST_WAIT;
               d_wait  = 8'd1;
            end
         ST_WAIT:
            if (~ext_valid | ext_ready) begin
               d_state = ST_IDLE;
               d_wait  = '0;
            end else if (q_wait == STARVE_LIMIT[7:0])
               d_state = ST_STEAL;
            else
               d_wait = q_wait + 8'd1;
         default: begin
            d_state = ST_IDLE;
            d_wait  = '0;
         end
      endcase
   end

   assign steal = q_state == ST_STEAL;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: CPU-priority arbiter for a single one-cycle-latency memory port.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved external master steal a slot.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW           = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cpu_valid,
   input  logic          cpu_write,
   input  logic [3:0]    cpu_wmask,
   input  logic [31:0]   cpu_wdata,
   input  logic [AW-1:0] cpu_addr,
   output logic [31:0]   cpu_rdata,
   output logic          cpu_stall,
   input  logic          ext_valid,
   input  logic          ext_write,
   input  logic [3:0]    ext_wmask,
   input  logic [31:0]   ext_wdata,
   input  logic [AW-1:0] ext_addr,
   output logic          ext_ready,
   output logic          ext_rvalid,
   output logic [31:0]   ext_rdata,
   output logic          mem_valid,
   output logic          mem_write,
   output logic [3:0]    mem_wmask,
   output logic [31:0]   mem_wdata,
   output logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_rdata
);
   logic   steal, ext_gnt, cpu_gnt, q_ext_read;
   owner_t q_owner;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("mem_port_arbiter: STARVE_LIMIT must be within 1..255");
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   mem_arb_starve_guard #(.STARVE_LIMIT(STARVE_LIMIT)) u_guard (
      .clk       (clk),
      .rstn      (rstn),
      .ext_valid (ext_valid),
      .ext_ready (ext_ready),
      .steal     (steal)
   );
`else
   assign steal = 1'b0;
`endif

   assign ext_gnt   = rstn & ext_valid & (~cpu_valid | steal);
   assign cpu_gnt   = rstn & cpu_valid & ~ext_gnt;
   assign ext_ready = ext_gnt;
   assign cpu_stall = rstn & steal;

   // Idle cycles still drive cpu_addr so a speculative CPU read sees data next cycle.
   assign mem_valid = ext_gnt | cpu_gnt;
   assign mem_write = ext_gnt ? ext_write : cpu_write;
   assign mem_wmask = ext_gnt ? ext_wmask : cpu_wmask;
   assign mem_wdata = ext_gnt ? ext_wdata : cpu_wdata;
   assign mem_addr  = ext_gnt ? ext_addr  : cpu_addr;

   assign cpu_rdata  = mem_rdata;
   assign ext_rdata  = mem_rdata;
   assign ext_rvalid = rstn & (q_owner == OWN_EXT) & q_ext_read;

   always_ff @(posedge clk)
      if (!rstn) begin
         q_owner    <= OWN_NONE;
         q_ext_read <= 1'b0;
      end else begin
         q_owner    <= ext_gnt ? OWN_EXT : cpu_gnt ? OWN_CPU : OWN_NONE;
         q_ext_read <= ext_gnt & ~ext_write;
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against
// a grant/starvation/memory model; honours MEM_ARB_STARVE_GUARD_EN like the RTL.
module tb_mem_port_arbiter;
   localparam int LIMIT = 3;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0, rstn = 1'b0;
   logic        cpu_valid = 0, cpu_write = 0, ext_valid = 0, ext_write = 0;
   logic [3:0]  cpu_wmask = 0, ext_wmask = 0, mem_wmask;
   logic [31:0] cpu_wdata = 0, ext_wdata = 0, cpu_addr = 0, ext_addr = 0;
   logic [31:0] cpu_rdata, ext_rdata, mem_wdata, mem_addr, mem_rdata;
   logic        cpu_stall, ext_ready, ext_rvalid, mem_valid, mem_write;

   mem_port_arbiter #(.AW(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rstn(rstn),
      .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_wmask(cpu_wmask),
      .cpu_wdata(cpu_wdata), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_valid(ext_valid), .ext_write(ext_write), .ext_wmask(ext_wmask),
      .ext_wdata(ext_wdata), .ext_addr(ext_addr), .ext_ready(ext_ready),
      .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] seed(int i);
      return 32'h1234_5678 ^ (32'(i ^ 4) * 32'h0101_0101);
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Environment RAM: 16 words selected by addr[5:2], one-cycle read latency.
   logic [31:0] ram [16];
   always @(posedge clk) begin
      if (!rstn) for (int i = 0; i < 16; i++) ram[i] <= seed(i);
      else if (mem_valid && mem_write) ram[mem_addr[5:2]] <= merge(ram[mem_addr[5:2]], mem_wdata, mem_wmask);
      mem_rdata <= ram[mem_addr[5:2]];
   end

   int n_tests = 0, n_fail = 0;
   logic [31:0] mm [16];
   int          k = 0;
   bit          pend_cpu = 0, pend_ext = 0, cpu_hold = 0, ext_hold = 0, m_eg = 0, m_steal = 0;
   logic [31:0] exp_cpu = 0, exp_ext = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: k counts consecutive refused cycles of the current ext request.
   task automatic sample();
      bit cg;
      @(negedge clk);
      if (!rstn) begin
         check("rst_ext_ready", 32'(ext_ready), 0);
         check("rst_cpu_stall", 32'(cpu_stall), 0);
         check("rst_ext_rvalid", 32'(ext_rvalid), 0);
         check("rst_mem_valid", 32'(mem_valid), 0);
         for (int i = 0; i < 16; i++) mm[i] = seed(i);
         k = 0; pend_cpu = 0; pend_ext = 0; cpu_hold = 0; ext_hold = 0; m_eg = 0; m_steal = 0;
         return;
      end
      m_steal = GUARD && (k == LIMIT + 1);
      m_eg    = ext_valid && (!cpu_valid || m_steal);
      cg      = cpu_valid && !m_eg;
      if (pend_cpu) check("cpu_rdata", cpu_rdata, exp_cpu);
      check("ext_rvalid", 32'(ext_rvalid), 32'(pend_ext));
      if (pend_ext) check("ext_rdata", ext_rdata, exp_ext);
      check("ext_ready", 32'(ext_ready), 32'(m_eg));
      check("cpu_stall", 32'(cpu_stall), 32'(m_steal));
      check("mem_valid", 32'(mem_valid), 32'(m_eg | cg));
      check("mem_addr", mem_addr, m_eg ? ext_addr : cpu_addr);
      if (m_eg || cg) begin
         check("mem_write", 32'(mem_write), 32'(m_eg ? ext_write : cpu_write));
         if (mem_write) begin
            check("mem_wdata", mem_wdata, m_eg ? ext_wdata : cpu_wdata);
            check("mem_wmask", 32'(mem_wmask), 32'(m_eg ? ext_wmask : cpu_wmask));
         end
      end
      pend_ext = m_eg && !ext_write;
      exp_ext  = mm[ext_addr[5:2]];
      pend_cpu = !m_eg && !(cg && cpu_write);
      exp_cpu  = mm[cpu_addr[5:2]];
      if (m_eg && ext_write) mm[ext_addr[5:2]] = merge(mm[ext_addr[5:2]], ext_wdata, ext_wmask);
      if (cg && cpu_write) mm[cpu_addr[5:2]] = merge(mm[cpu_addr[5:2]], cpu_wdata, cpu_wmask);
      cpu_hold = m_steal && cpu_valid;
      ext_hold = ext_valid && !m_eg;
      k = (m_steal || m_eg || !ext_valid) ? 0 : k + 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      if (!cpu_hold) begin
         cpu_valid = $urandom_range(0, 9) < 7;
         cpu_write = 1'($urandom_range(0, 1));
         cpu_wmask = 4'($urandom);
         cpu_wdata = $urandom;
         cpu_addr  = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
      end
      if (ext_hold) begin
         if (!(GUARD && k == LIMIT + 1) && $urandom_range(0, 7) == 0) ext_valid = 1'b0;
      end else begin
         ext_valid = 1'($urandom_range(0, 1));
         ext_write = 1'($urandom_range(0, 1));
         ext_wmask = 4'($urandom);
         ext_wdata = $urandom;
         ext_addr  = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
      end
   endtask

   initial begin
      bit stall_seen = 0, ready_seen = 0;
      repeat (3) begin sample(); tick(); end
      rstn = 1'b1;

      cpu_valid = 1; cpu_write = 0; cpu_addr = 32'h8000_0010;
      sample(); check("cpu_only_addr", mem_addr, 32'h8000_0010); tick();
      cpu_valid = 0;
      sample(); check("cpu_only_rdata", cpu_rdata, 32'h1234_5678);
      check("cpu_only_rvalid", 32'(ext_rvalid), 0); tick();

      ext_valid = 1; ext_write = 1; ext_addr = 32'h8004_0000; ext_wdata = 32'hDEAD_BEEF; ext_wmask = 4'hF;
      sample(); check("ext_wr_ready", 32'(ext_ready), 1); tick();
      ext_write = 0;
      sample(); check("ext_rd_ready", 32'(ext_ready), 1); tick();
      ext_valid = 0;
      sample(); check("ext_rd_rvalid", 32'(ext_rvalid), 1);
      check("ext_rd_data", ext_rdata, 32'hDEAD_BEEF); tick();

      cpu_valid = 1; cpu_write = 0; cpu_addr = 32'h8000_0020;
      ext_valid = 1; ext_write = 0; ext_addr = 32'h8000_0004;
`ifdef MEM_ARB_STARVE_GUARD_EN
      for (int i = 0; i < 6; i++) begin
         sample();
         check($sformatf("starve_ready_%0d", i), 32'(ext_ready), 32'(i == 4));
         check($sformatf("starve_stall_%0d", i), 32'(cpu_stall), 32'(i == 4));
         check($sformatf("starve_addr_%0d", i), mem_addr, i == 4 ? 32'h8000_0004 : 32'h8000_0020);
         tick();
      end
`else
      for (int i = 0; i < 300; i++) begin
         sample();
         if (i == 0) check("contend_addr", mem_addr, 32'h8000_0020);
         stall_seen |= cpu_stall;
         ready_seen |= ext_ready;
         tick();
      end
      check("nostarve_stall_seen", 32'(stall_seen), 0);
      check("nostarve_ready_seen", 32'(ready_seen), 0);
`endif

      cpu_valid = 0; ext_valid = 1; ext_write = 0; ext_addr = 32'h8000_0008;
      sample(); check("rst_rd_ready", 32'(ext_ready), 1); tick();
      rstn = 1'b0; ext_valid = 0;
      sample(); check("rst_rd_rvalid", 32'(ext_rvalid), 0); tick();
      sample(); tick();
      rstn = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         sample();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
